// File: rtl/cbl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cbl_pkg
// Description : Shared constants, types and the write-priority resolver for
//               the CaballoLoco register file.
// Revision    : 1.0 - initial multi-port release
// ============================================================================
package cbl_pkg;

    localparam int CBL_DATA_WIDTH = 32;
    localparam int CBL_NUM_REG    = 32;

    // Widest write-port count the resolver accepts; callers zero-pad.
    localparam int CBL_MAX_WRITE  = 16;
    localparam int CBL_PORT_IDX_W = $clog2(CBL_MAX_WRITE);

    // Outcome of resolving all write ports aimed at one register.
    typedef struct packed {
        logic                      hit;      // at least one port targets it
        logic                      conflict; // two or more ports target it
        logic [CBL_PORT_IDX_W-1:0] idx;      // winning (highest) port index
    } wr_win_t;

    // Highest set bit wins; more than one set bit flags a conflict.
    function automatic wr_win_t resolve_write(input logic [CBL_MAX_WRITE-1:0] hits);
        wr_win_t res;
        int      cnt;
        res = '0;
        cnt = 0;
        for (int p = 0; p < CBL_MAX_WRITE; p++) begin
            if (hits[p]) begin
                res.hit = 1'b1;
                res.idx = CBL_PORT_IDX_W'(p);
                cnt     = cnt + 1;
            end
        end
        res.conflict = (cnt > 1);
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_scoreboard
// Description : Per-register busy bits. A reserve sets a bit, a committed
//               write clears it; a same-cycle reserve beats the clear.
// Revision    : 1.0 - initial multi-port release
// ============================================================================
module reg_file_scoreboard
    import cbl_pkg::*;
#(
    parameter int NUM_REG = CBL_NUM_REG,
    parameter int SEL_W   = $clog2(NUM_REG)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_reserve_enable,
    input  logic [SEL_W-1:0]   i_reserve_select,
    input  logic [NUM_REG-1:0] i_write_clear,
    output logic [NUM_REG-1:0] o_busy
);

    generate
        for (genvar r = 0; r < NUM_REG; r++) begin : g_busy
            logic r_busy;

            // New producer supersedes the retiring one, so set has priority.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_busy <= 1'b0;
                end else if (i_reserve_enable && (i_reserve_select == SEL_W'(r))) begin
                    r_busy <= 1'b1;
                end else if (i_write_clear[r]) begin
                    r_busy <= 1'b0;
                end
            end

            assign o_busy[r] = r_busy;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_mp
// Description : Multi-port register file with fixed-priority writes,
//               optional write-to-read bypass, optional hardwired zero
//               register and a busy scoreboard for hazard detection.
// Revision    : 1.0 - initial multi-port release
// ============================================================================
module reg_file_mp
    import cbl_pkg::*;
#(
    parameter int DATA_WIDTH = CBL_DATA_WIDTH,
    parameter int NUM_REG    = CBL_NUM_REG,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int SEL_W      = $clog2(NUM_REG)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_WRITE-1:0]                 i_write_enable,
    input  logic [NUM_WRITE-1:0][SEL_W-1:0]      i_write_select,
    input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] i_write_data,
    input  logic [NUM_READ-1:0][SEL_W-1:0]       i_read_select,
    output logic [NUM_READ-1:0][DATA_WIDTH-1:0]  o_read_data,
    input  logic                                 i_reserve_enable,
    input  logic [SEL_W-1:0]                     i_reserve_select,
    output logic [NUM_READ-1:0]                  o_read_busy,
    output logic [NUM_REG-1:0]                   o_busy,
    output logic                                 o_conflict
);

    logic [NUM_REG-1:0][DATA_WIDTH-1:0] w_regs;      // committed contents
    logic [NUM_REG-1:0][DATA_WIDTH-1:0] w_byp_data;  // winning write data
    logic [NUM_REG-1:0]                 w_wr_hit;    // valid write this cycle
    logic [NUM_REG-1:0]                 w_rsv_hit;   // valid reserve this cycle
    logic [NUM_REG-1:0]                 w_conf;      // per-register conflict
    logic                               w_reserve_valid;

    // Register 0 is untouchable when hardwired to zero.
    assign w_reserve_valid = i_reserve_enable &&
                             !((ZERO_REG != 0) && (i_reserve_select == '0));

    generate
        for (genvar r = 0; r < NUM_REG; r++) begin : g_reg
            localparam bit c_WRITABLE = !((ZERO_REG != 0) && (r == 0));

            logic [NUM_WRITE-1:0]  w_hits;
            wr_win_t               w_win;
            logic [DATA_WIDTH-1:0] w_wdata;
            logic [DATA_WIDTH-1:0] r_data;

            // Decode which ports aim here, resolve priority, pick the data.
            always_comb begin
                logic [CBL_MAX_WRITE-1:0] v_hits;
                w_hits = '0;
                for (int p = 0; p < NUM_WRITE; p++) begin
                    w_hits[p] = c_WRITABLE && i_write_enable[p] &&
                                (i_write_select[p] == SEL_W'(r));
                end
                v_hits                = '0;
                v_hits[NUM_WRITE-1:0] = w_hits;
                w_win                 = resolve_write(v_hits);
                w_wdata               = '0;
                for (int p = 0; p < NUM_WRITE; p++) begin
                    if (w_win.hit && (CBL_PORT_IDX_W'(p) == w_win.idx)) begin
                        w_wdata = i_write_data[p];
                    end
                end
            end

            // Commit the winning write on the edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data <= '0;
                end else if (w_win.hit) begin
                    r_data <= w_wdata;
                end
            end

            assign w_regs[r]     = r_data;
            assign w_byp_data[r] = w_wdata;
            assign w_wr_hit[r]   = w_win.hit;
            assign w_conf[r]     = w_win.conflict;
            assign w_rsv_hit[r]  = w_reserve_valid && (i_reserve_select == SEL_W'(r));
        end
    endgenerate

    assign o_conflict = |w_conf;

    reg_file_scoreboard #(
        .NUM_REG (NUM_REG),
        .SEL_W   (SEL_W)
    ) u_scoreboard (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_reserve_enable (w_reserve_valid),
        .i_reserve_select (i_reserve_select),
        .i_write_clear    (w_wr_hit),
        .o_busy           (o_busy)
    );

    // Read mux: out-of-range selects fall through to zero data / not busy.
    always_comb begin
        o_read_data = '0;
        o_read_busy = '0;
        for (int q = 0; q < NUM_READ; q++) begin
            for (int r = 0; r < NUM_REG; r++) begin
                if (i_read_select[q] == SEL_W'(r)) begin
                    if ((BYPASS != 0) && w_wr_hit[r]) begin
                        o_read_data[q] = w_byp_data[r];
                        o_read_busy[q] = w_rsv_hit[r];
                    end else begin
                        o_read_data[q] = w_regs[r];
                        o_read_busy[q] = o_busy[r];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the CaballoLoco processor core, and the successor to the single-write-port register bank. It provides NUM_WRITE write ports with fixed priority, NUM_READ addressed read ports, and optional write-to-read bypass. It also offers an optional hardwired-zero register 0 and a per-register busy scoreboard that the issue stage uses for hazard detection. It sits between decode/issue (read and reserve) and writeback (write).

## Interface
Parameters:
- DATA_WIDTH, 32: register width in bits.
- NUM_REG, 32: number of registers, ≥2. SEL_W = $clog2(NUM_REG).
- NUM_READ, 2: number of read ports, ≥1.
- NUM_WRITE, 2: number of write ports, ≥1.
- ZERO_REG, 1: 1 hardwires register 0 to zero.
- BYPASS, 1: 1 forwards same-cycle write data and busy-clear to the read ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_write_enable  in  [NUM_WRITE]  per-port write strobe.
- i_write_select  in  [NUM_WRITE][SEL_W]  write register index.
- i_write_data  in  [NUM_WRITE][DATA_WIDTH]  write data.
- i_read_select  in  [NUM_READ][SEL_W]  read register index.
- o_read_data  out  [NUM_READ][DATA_WIDTH]  read data (combinational from state, plus bypass).
- i_reserve_enable  in  1  marks a register busy (a producer has issued).
- i_reserve_select  in  SEL_W  register to reserve.
- o_read_busy  out  [NUM_READ]  busy bit of each read-selected register.
- o_busy  out  [NUM_REG]  full scoreboard vector.
- o_conflict  out  1  combinational flag: two or more enabled write ports target the same valid register this cycle.

## Operation
- Reset (rst_n low, asynchronous): all registers are 0 and all busy bits are 0. Consequently o_read_data = 0, o_read_busy = 0, o_busy = 0, and o_conflict reflects only the inputs.
- Write: on each rising edge, every enabled port with select < NUM_REG updates its register.
  - When several ports target the same register, the highest port index wins and o_conflict is 1 for that cycle.
- Invalid selects (≥ NUM_REG):
  - Write: ignored; no state change, no conflict contribution.
  - Read: returns data 0 and busy 0.
  - Reserve: ignored.
- ZERO_REG=1: writes and reserves to register 0 are ignored. Register 0 always reads 0 and is never busy.
- Scoreboard: on a clock edge, a valid i_reserve_enable sets busy[i_reserve_select], and a valid write clears busy[i_write_select].
  - If a reserve and a write hit the same register in the same cycle, the reserve wins and busy stays 1, because a new producer supersedes the old one.
- Read with BYPASS=0: o_read_data is the current register contents; o_read_busy is the current busy bit.
- Read with BYPASS=1:
  - If a valid enabled write (the priority winner) targets the read-selected register, o_read_data shows that write data in the same cycle.
  - o_read_busy shows 0 in that case, unless a same-cycle reserve also targets that register.

## Timing
- Read latency: 0 cycles (combinational).
- Write visibility: the next cycle, or the same cycle when BYPASS=1.
- Busy set/clear takes effect after the edge. Only the bypass path reflects busy changes in the same cycle.
- Reset assertion mid-cycle clears state immediately. Deassertion is taken as synchronous to clk at the integration level.
- No handshake; all strobes are single-cycle qualifiers.

## Structure
- Shared package cbl_pkg:
  - Default constants: CBL_DATA_WIDTH = 32, CBL_NUM_REG = 32.
  - The function for write-priority resolution, returning the winning port index and a conflict flag.
- Sub-module reg_file_scoreboard (NUM_REG, SEL_W; clk, rst_n, reserve, write-clear vector, o_busy) holds the busy bits.
- The data array and the bypass mux stay in reg_file_mp.

## Test plan
Bench parameters: DATA_WIDTH=8, NUM_REG=6, NUM_READ=2, NUM_WRITE=2, ZERO_REG=1, BYPASS=1.
- Reset check: hold rst_n=0 mid-run after writing AA to reg 2 → reg 2 reads 00 immediately, o_busy=000000.
- Basic write/read: port0 writes reg2=AA, port1 writes reg1=BB in the same cycle → next cycle read ports (2,1) return AA, BB. o_conflict=0.
- Write conflict: port0 writes reg3=11 and port1 writes reg3=22 → o_conflict=1 that cycle; reg3 reads 22 afterwards.
- Zero register and invalid select: write reg0=CC → reg0 reads 00. Write select 7 with data CC → no register changes. Reading select 7 returns 00 with busy 0.
- Bypass: with reg4=00, port0 writes reg4=5A while read port 0 selects reg4 → o_read_data[0]=5A in the same cycle.
- Scoreboard:
  - Reserve reg5 → o_busy[5]=1 next cycle.
  - Write reg5=77 → o_read_busy=0 in the same cycle (bypass); busy[5]=0 after the edge.
  - Reserve and write reg5 together → busy[5] stays 1.
